// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: sequential IEEE-754 single-precision multiplier with start/busy/done handshake
module fp32_mul_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a_bits,
   input  logic [31:0] b_bits,
   output logic        busy,
   output logic        done,
   output logic [31:0] z_bits
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
   state_t             state;
   logic [31:0]        a_r, b_r, res;
   logic [47:0]        acc, mcand;
   logic [23:0]        mplier, mant;
   logic [4:0]         cnt;
   logic               guard, sticky;
   logic signed [9:0]  exp_sum, exp_r;
   logic               sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic               is_nan, is_inf, is_zero, rnd_inc, carry;
   logic [24:0]        mant_r;
   logic [22:0]        mant_n;
   logic [31:0]        round_res;
   // operand classification and round-to-nearest-even packing of the normalized product
   always_comb begin
      sgn       = a_r[31] ^ b_r[31];
      a_zero    = a_r[30:23] == 8'h00;
      b_zero    = b_r[30:23] == 8'h00;
      a_inf     = a_r[30:23] == 8'hFF && a_r[22:0] == 23'h0;
      b_inf     = b_r[30:23] == 8'hFF && b_r[22:0] == 23'h0;
      a_nan     = a_r[30:23] == 8'hFF && a_r[22:0] != 23'h0;
      b_nan     = b_r[30:23] == 8'hFF && b_r[22:0] != 23'h0;
      is_nan    = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      is_inf    = a_inf | b_inf;
      is_zero   = a_zero | b_zero;
      rnd_inc   = guard & (sticky | mant[0]);
      mant_r    = {1'b0, mant} + {24'h0, rnd_inc};
      carry     = mant_r[24];
      mant_n    = carry ? mant_r[23:1] : mant_r[22:0];
      exp_r     = exp_sum + {9'h0, carry};
      round_res = exp_r >= 10'sd255 ? {sgn, 8'hFF, 23'h0} :
                  exp_r <= 10'sd0   ? {sgn, 31'h0} : {sgn, exp_r[7:0], mant_n};
   end
   // control FSM with shift-add mantissa datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         z_bits <= 32'h0;
         cnt    <= 5'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_r   <= a_bits;
               b_r   <= b_bits;
               busy  <= 1'b1;
               state <= UNPACK;
            end
            UNPACK: if (is_nan | is_inf | is_zero) begin
               res   <= is_nan ? QNAN : is_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 31'h0};
               state <= DONE;
            end else begin
               mcand   <= {24'h0, 1'b1, b_r[22:0]};
               mplier  <= {1'b1, a_r[22:0]};
               acc     <= 48'h0;
               exp_sum <= {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'd127;
               cnt     <= 5'd0;
               state   <= MUL;
            end
            MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               if (cnt == 5'd23) state <= NORM;
            end
            NORM: begin
               mant    <= acc[47] ? acc[47:24] : acc[46:23];
               guard   <= acc[47] ? acc[23] : acc[22];
               sticky  <= acc[47] ? |acc[22:0] : |acc[21:0];
               exp_sum <= exp_sum + {9'h0, acc[47]};
               state   <= ROUND;
            end
            ROUND: begin
               res   <= round_res;
               state <= DONE;
            end
            DONE: begin
               z_bits <= res;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq: randomized and directed checks of fp32_mul_seq against an arithmetic reference
module tb_fp32_mul_seq;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] a_bits = 32'h0, b_bits = 32'h0;
   logic        busy, done;
   logic [31:0] z_bits;
   int          total = 0, passed = 0;

   fp32_mul_seq dut (.clk(clk), .rst(rst), .start(start), .a_bits(a_bits), .b_bits(b_bits),
                     .busy(busy), .done(done), .z_bits(z_bits));

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, sh;
      bit an, bn, ai, bi, az, bz;
      longint unsigned p, q, r, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      an = ea == 255 && a[22:0] != 0;
      bn = eb == 255 && b[22:0] != 0;
      ai = ea == 255 && a[22:0] == 0;
      bi = eb == 255 && b[22:0] == 0;
      az = ea == 0;
      bz = eb == 0;
      if (an || bn || (ai && bz) || (az && bi)) return QNAN;
      if (ai || bi) return {s, 8'hFF, 23'h0};
      if (az || bz) return {s, 31'h0};
      p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e  = ea + eb - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      q    = p >> sh;
      r    = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), q[22:0]};
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 2 : 28;
   endfunction

   function automatic logic [31:0] rand_op();
      int sel;
      logic [7:0] e;
      logic [22:0] f;
      sel = $urandom_range(0, 9);
      f   = 23'($urandom);
      e   = sel == 0 ? 8'h00 : sel <= 2 ? 8'hFF : 8'($urandom_range(1, 254));
      if (sel == 1) f = 23'h0;
      return {1'($urandom), e, f};
   endfunction

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] z,
                        output int lat, output int busy_bad, output logic busy_at_done);
      @(negedge clk);
      start  = 1'b1;
      a_bits = a;
      b_bits = b;
      @(posedge clk);
      #1 start = 1'b0;
      lat      = 0;
      busy_bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) break;
         if (!busy) busy_bad++;
         @(posedge clk);
         #1 lat++;
      end
      z            = z_bits;
      busy_at_done = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (z_bits !== 32'h0) $display("FAIL reset_z got %h want 0", z_bits); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] va [10] = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3FC00000, 32'h7F800000,
                               32'hFF800000, 32'h00000001, 32'h7F7FFFFF, 32'h00800000, 32'h80800000};
      logic [31:0] vb [10] = '{32'h40400000, 32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h00000000,
                               32'h40000000, 32'h7F000000, 32'h40000000, 32'h3F000000, 32'h3F000000};
      logic [31:0] vz [10] = '{32'h40C00000, 32'hC0C00000, 32'h3F800002, 32'h40100000, 32'h7FC00000,
                               32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h80000000};
      int          vl [10] = '{28, 28, 28, 28, 2, 2, 2, 28, 28, 28};
      logic [31:0] z;
      int          lat, bb;
      logic        bd;
      for (int i = 0; i < 10; i++) begin
         do_op(va[i], vb[i], z, lat, bb, bd);
         total++; if (z !== vz[i]) $display("FAIL dir_z[%0d] got %h want %h", i, z, vz[i]); else passed++;
         total++; if (ref_mul(va[i], vb[i]) !== vz[i]) $display("FAIL dir_model[%0d] got %h want %h", i, ref_mul(va[i], vb[i]), vz[i]); else passed++;
         total++; if (lat !== vl[i]) $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, vl[i]); else passed++;
         total++; if (bb !== 0) $display("FAIL dir_busy_low[%0d] got %0d cycles want 0", i, bb); else passed++;
         total++; if (bd !== 1'b0) $display("FAIL dir_busy_at_done[%0d] got %b want 0", i, bd); else passed++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, z;
      int          lat, bb;
      logic        bd;
      for (int i = 0; i < 40; i++) begin
         a = rand_op();
         b = rand_op();
         do_op(a, b, z, lat, bb, bd);
         total++; if (z !== ref_mul(a, b)) $display("FAIL rand_z %h*%h got %h want %h", a, b, z, ref_mul(a, b)); else passed++;
         total++; if (lat !== exp_lat(a, b)) $display("FAIL rand_lat %h*%h got %0d want %0d", a, b, lat, exp_lat(a, b)); else passed++;
      end
   endtask

   task automatic test_busy_ignore();
      int          n = 0, bad = 0;
      logic [31:0] held;
      @(negedge clk);
      start  = 1'b1;
      a_bits = 32'h40000000;
      b_bits = 32'h40400000;
      @(posedge clk);
      #1;
      for (int i = 0; i < 100; i++) begin
         if (done) break;
         start  = 1'b1;
         a_bits = $urandom;
         b_bits = $urandom;
         @(posedge clk);
         #1 n++;
      end
      start = 1'b0;
      held  = z_bits;
      total++; if (held !== 32'h40C00000) $display("FAIL ignore_z got %h want 40c00000", held); else passed++;
      total++; if (n !== 28) $display("FAIL ignore_lat got %0d want 28", n); else passed++;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (z_bits !== held || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      total++; if (bad !== 0) $display("FAIL hold_after_done got %0d bad cycles want 0", bad); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] z;
      int          lat, bb;
      logic        bd;
      do_op(32'h3FC00000, 32'h3FC00000, z, lat, bb, bd);
      do_op(32'hC0000000, 32'h40400000, z, lat, bb, bd);
      total++; if (z !== 32'hC0C00000) $display("FAIL b2b_z got %h want c0c00000", z); else passed++;
      total++; if (lat !== 28) $display("FAIL b2b_lat got %0d want 28", lat); else passed++;
      @(posedge clk);
      #1;
      total++; if (done !== 1'b0) $display("FAIL b2b_done_pulse got %b want 0", done); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b, z;
      int          lat, bb, seen = 0;
      logic        bd;
      @(negedge clk);
      start  = 1'b1;
      a_bits = 32'h40490FDB;
      b_bits = 32'h402DF854;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
      total++; if (z_bits !== 32'h0) $display("FAIL rstmid_z got %h want 0", z_bits); else passed++;
      rst = 1'b0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk);
         #1 if (done || busy) seen++;
      end
      total++; if (seen !== 0) $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); else passed++;
      a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      do_op(a, b, z, lat, bb, bd);
      total++; if (z !== ref_mul(a, b)) $display("FAIL rstmid_fresh_z got %h want %h", z, ref_mul(a, b)); else passed++;
      total++; if (lat !== 28) $display("FAIL rstmid_fresh_lat got %0d want 28", lat); else passed++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
